// File: rtl/uart_byte_rx.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling, LSB-first byte out with one-cycle strobe.
// Optional even-parity bit is enabled by defining UART_PARITY_EN.
module uart_byte_rx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BIT    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic [DATA_BIT-1:0] rx_data,
    output logic                rx_valid,
    output logic                frame_err,
    output logic                busy,
    output logic                parity_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_BIT-1:0] shift_q, shift_d;
    logic [DATA_BIT-1:0] rx_data_q;
    logic                rx_valid_q, frame_err_q;
    logic                strobe;
    logic                rx_s;
`ifdef UART_PARITY_EN
    logic                par_q, par_d;
    logic                parity_err_q;
`endif

    assign rx_s = sync2_q;

    // State register, synchronizer and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            rx_valid_q <= strobe;
`ifdef UART_PARITY_EN
            par_q <= par_d;
`endif
            if (strobe) begin
                rx_data_q   <= shift_q;
                frame_err_q <= ~rx_s;
`ifdef UART_PARITY_EN
                parity_err_q <= (par_q != ^shift_q);
`endif
            end
        end
    end

    // Next-state logic; the counter restarts on every state entry so samples stay mid-bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_PARITY_EN
        par_d = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BIT-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy   = (state_q != IDLE);
        strobe = (state_q == STOP) && (cnt_q == FULL_LAST);
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: three receivers at 10, 9 and 11 clocks per bit share clock and reset.
// Parity frames and checks are included when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_byte_rx;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       lineVal = 1'b1;
    int         lane = 0;
    int         checkCnt = 0;
    int         errCnt = 0;

    logic       rx0, rx1, rx2;
    logic [7:0] data0, data1, data2;
    logic       valid0, valid1, valid2;
    logic       ferr0, ferr1, ferr2;
    logic       busy0, busy1, busy2;
    logic       perr0, perr1, perr2;

    logic [7:0] dataV[3];
    logic       validV[3];
    logic       ferrV[3];
    logic       perrV[3];
    logic       prevValid[3] = '{1'b0, 1'b0, 1'b0};
    int         strobeCnt[3] = '{0, 0, 0};
    int         widthErrs[3] = '{0, 0, 0};
    logic [7:0] dataLog[3][16];
    logic       ferrLog[3][16];
    logic       perrLog[3][16];
`ifdef UART_PARITY_EN
    logic       parFlip = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rx0 = (lane == 0) ? lineVal : 1'b1;
    assign rx1 = (lane == 1) ? lineVal : 1'b1;
    assign rx2 = (lane == 2) ? lineVal : 1'b1;

    uart_byte_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8)) dut0 (
        .clk(clk), .reset(resetN), .rx(rx0), .rx_data(data0), .rx_valid(valid0),
        .frame_err(ferr0), .busy(busy0), .parity_err(perr0));
    uart_byte_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(111_111), .DATA_BIT(8)) dut1 (
        .clk(clk), .reset(resetN), .rx(rx1), .rx_data(data1), .rx_valid(valid1),
        .frame_err(ferr1), .busy(busy1), .parity_err(perr1));
    uart_byte_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(90_909), .DATA_BIT(8)) dut2 (
        .clk(clk), .reset(resetN), .rx(rx2), .rx_data(data2), .rx_valid(valid2),
        .frame_err(ferr2), .busy(busy2), .parity_err(perr2));

    assign dataV[0] = data0;  assign dataV[1] = data1;  assign dataV[2] = data2;
    assign validV[0] = valid0; assign validV[1] = valid1; assign validV[2] = valid2;
    assign ferrV[0] = ferr0;  assign ferrV[1] = ferr1;  assign ferrV[2] = ferr2;
    assign perrV[0] = perr0;  assign perrV[1] = perr1;  assign perrV[2] = perr2;

    // Log every strobe shortly after the clock edge, and flag strobes wider than one cycle
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            if (validV[i]) begin
                if (strobeCnt[i] < 16) begin
                    dataLog[i][strobeCnt[i]] = dataV[i];
                    ferrLog[i][strobeCnt[i]] = ferrV[i];
                    perrLog[i][strobeCnt[i]] = perrV[i];
                end
                strobeCnt[i]++;
                if (prevValid[i]) widthErrs[i]++;
            end
            prevValid[i] = validV[i];
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic b, input int period);
        lineVal = b;
        waitClk(period);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int period);
        applyStimulus(1'b0, period);
        for (int i = 0; i < 8; i++) applyStimulus(b[i], period);
`ifdef UART_PARITY_EN
        applyStimulus((^b) ^ parFlip, period);
`endif
        applyStimulus(stopBit, period);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base;
        int periods[3];
        periods = '{10, 9, 11};

        $display("[TB] reset with toggling line");
        for (int i = 0; i < 10; i++) begin
            lineVal = i[0];
            waitClk(2);
        end
        lineVal = 1'b1;
        waitClk(3);
        resetN = 1'b1;
        waitClk(3);
        checkOutput("reset_rx_data", 32'(data0), 32'h0);
        checkOutput("reset_rx_valid", 32'(valid0), 32'h0);
        checkOutput("reset_frame_err", 32'(ferr0), 32'h0);
        checkOutput("reset_busy", 32'(busy0), 32'h0);
        checkOutput("reset_parity_err", 32'(perr0), 32'h0);

        $display("[TB] single frame 0xA5");
        lane = 0;
        sendFrame(8'hA5, 1'b1, 10);
        waitClk(20);
        checkOutput("a5_strobes", 32'(strobeCnt[0]), 32'd1);
        checkOutput("a5_data", 32'(dataLog[0][0]), 32'hA5);
        checkOutput("a5_frame_err", 32'(ferrLog[0][0]), 32'h0);
        checkOutput("a5_width", 32'(widthErrs[0]), 32'd0);
        checkOutput("a5_busy_after", 32'(busy0), 32'h0);
        checkOutput("a5_rx_data_held", 32'(data0), 32'hA5);

        $display("[TB] short glitch");
        lineVal = 1'b0;
        waitClk(3);
        lineVal = 1'b1;
        waitClk(8);
        checkOutput("glitch_busy", 32'(busy0), 32'h0);
        checkOutput("glitch_strobes", 32'(strobeCnt[0]), 32'd1);

        $display("[TB] framing error with stuck-low line");
        sendFrame(8'h3C, 1'b0, 10);
        lineVal = 1'b0;
        waitClk(30);
        checkOutput("ferr_strobes", 32'(strobeCnt[0]), 32'd2);
        checkOutput("ferr_data", 32'(dataLog[0][1]), 32'h3C);
        checkOutput("ferr_flag", 32'(ferrLog[0][1]), 32'h1);
        checkOutput("ferr_busy_stuck", 32'(busy0), 32'h1);
        checkOutput("ferr_flag_held", 32'(ferr0), 32'h1);
        lineVal = 1'b1;
        waitClk(20);
        checkOutput("ferr_no_retrigger", 32'(strobeCnt[0]), 32'd2);
        checkOutput("ferr_busy_released", 32'(busy0), 32'h0);

        for (int l = 0; l < 3; l++) begin
            $display("[TB] back-to-back frames, lane %0d, %0d clocks per bit", l, periods[l]);
            lane = l;
            base = strobeCnt[l];
            sendFrame(8'h00, 1'b1, periods[l]);
            sendFrame(8'hFF, 1'b1, periods[l]);
            sendFrame(8'h81, 1'b1, periods[l]);
            waitClk(30);
            checkOutput($sformatf("b2b_strobes_l%0d", l), 32'(strobeCnt[l] - base), 32'd3);
            checkOutput($sformatf("b2b_data0_l%0d", l), 32'(dataLog[l][base]), 32'h00);
            checkOutput($sformatf("b2b_data1_l%0d", l), 32'(dataLog[l][base + 1]), 32'hFF);
            checkOutput($sformatf("b2b_data2_l%0d", l), 32'(dataLog[l][base + 2]), 32'h81);
            checkOutput($sformatf("b2b_ferr_l%0d", l),
                        32'({ferrLog[l][base], ferrLog[l][base + 1], ferrLog[l][base + 2]}), 32'h0);
            checkOutput($sformatf("b2b_width_l%0d", l), 32'(widthErrs[l]), 32'd0);
        end
        lane = 0;

`ifdef UART_PARITY_EN
        $display("[TB] parity frames");
        base = strobeCnt[0];
        parFlip = 1'b0;
        sendFrame(8'h07, 1'b1, 10);
        parFlip = 1'b1;
        sendFrame(8'h07, 1'b1, 10);
        parFlip = 1'b0;
        waitClk(20);
        checkOutput("par_strobes", 32'(strobeCnt[0] - base), 32'd2);
        checkOutput("par_good", 32'(perrLog[0][base]), 32'h0);
        checkOutput("par_bad", 32'(perrLog[0][base + 1]), 32'h1);
        checkOutput("par_data", 32'(dataLog[0][base + 1]), 32'h07);
`endif

        $display("[TB] reset during data bit 4");
        base = strobeCnt[0];
        applyStimulus(1'b0, 10);
        for (int i = 0; i < 4; i++) applyStimulus(i < 3 ? 1'b1 : 1'b0, 10);
        lineVal = 1'b0;
        waitClk(5);
        resetN = 1'b0;
        waitClk(2);
        checkOutput("midreset_busy", 32'(busy0), 32'h0);
        waitClk(60);
        lineVal = 1'b1;
        waitClk(5);
        resetN = 1'b1;
        waitClk(30);
        checkOutput("midreset_no_strobe", 32'(strobeCnt[0] - base), 32'd0);
        checkOutput("midreset_rx_data", 32'(data0), 32'h0);
        checkOutput("midreset_busy_after", 32'(busy0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end
endmodule
